// File: rtl/serial_adder_subtractor.sv
// Bit-serial two's-complement adder/subtractor.
// One bit per clock, LSB first, with a single carry flip-flop. opcode 0 adds,
// opcode 1 subtracts by inverting b and seeding the carry with 1.
// An operation takes WIDTH+1 cycles from the accepting edge to the next
// accepting edge.
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last completed result
// S_RUN   | shifting operands, one bit per clock
// S_DONE  | one-cycle done pulse; start here chains the next operation
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   request, sampled in S_IDLE and S_DONE only
//   a, b     in   operands [WIDTH], captured on an accepted start
//   opcode   in   0 = a+b, 1 = a-b, captured on an accepted start
//   busy     out  high while bits are being processed
//   done     out  one-cycle completion pulse
//   result   out  sum or difference mod 2^WIDTH, held until the next completion
//   cout     out  carry out of MSB (for subtract, 1 = no borrow)
//   overflow out  signed overflow
module serial_adder_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             opcode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             op;
  logic             carry;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             bi, s, carry_nxt;

  assign last_bit  = (count == LAST);
  assign bi        = b_sh[0] ^ op;
  assign s         = a_sh[0] ^ bi ^ carry;
  assign carry_nxt = (a_sh[0] & bi) | (bi & carry) | (a_sh[0] & carry);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      op       <= 1'b0;
      carry    <= 1'b0;
      count    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      op    <= opcode;
      carry <= opcode;
      count <= '0;
    end else if (state == S_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= {s, sum_sh[WIDTH-1:1]};
      carry  <= carry_nxt;
      count  <= count + CW'(1);
      if (last_bit) begin
        // sum_sh is one shift short here, so the final bit is merged in directly.
        // carry still holds the carry into the MSB at this edge.
        result   <= {s, sum_sh[WIDTH-1:1]};
        cout     <= carry_nxt;
        overflow <= carry ^ carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_subtractor.sv
module tb_serial_adder_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, start, opcode;
  logic [W-1:0] a, b;
  logic         busy, done, cout, overflow;
  logic [W-1:0] result;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_adder_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .opcode(opcode),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: {overflow, cout, result} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sub);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         v;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else     full = {1'b0, x} + {1'b0, y};
    r = full[W-1:0];
    if (sub) v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    else     v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, full[W], r};
  endfunction

  // Issue one operation from IDLE and wait for done; returns number of busy
  // cycles seen and whether done arrived within the budget. Ends at the
  // negedge where done is high.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                        output int nbusy, output logic got_done);
    int guard;
    @(negedge clk);
    start = 1'b1; a = x; b = y; opcode = sub;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; guard = 0;
    while (!done && guard < 40) begin
      if (busy) nbusy++;
      guard++;
      @(negedge clk);
    end
    got_done = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; opcode = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (result !== 8'h00)  begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
    total++; if (cout !== 1'b0)     begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int nb; logic gd;
    run_op(8'h35, 8'h4A, 1'b0, nb, gd);
    total++; if (gd !== 1'b1)    begin bad++; $display("FAIL basic_timeout done=%b", gd); end
    total++; if (nb != W)        begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", nb, W); end
    total++; if (result !== 8'h7F) begin bad++; $display("FAIL basic_result got=%h exp=7f", result); end
    total++; if ({cout, overflow} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b%b exp=00", cout, overflow); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_pulse done=%b busy=%b exp=0,0", done, busy); end
  endtask

  task automatic test_edges();
    logic [W-1:0] xs [6] = '{8'hFF, 8'h7F, 8'h05, 8'h80, 8'h10, 8'h00};
    logic [W-1:0] ys [6] = '{8'h01, 8'h01, 8'h07, 8'h01, 8'h10, 8'h01};
    logic         ops[6] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    logic [W+1:0] exp[6] = '{10'b0_1_00000000, 10'b1_0_10000000, 10'b0_0_11111110,
                             10'b1_1_01111111, 10'b0_1_00000000, 10'b0_0_11111111};
    int nb; logic gd;
    for (int i = 0; i < 6; i++) begin
      run_op(xs[i], ys[i], ops[i], nb, gd);
      total++;
      if (!gd || {overflow, cout, result} !== exp[i]) begin
        bad++;
        $display("FAIL edge_%0d got v=%b c=%b r=%h exp v=%b c=%b r=%h done=%b",
                 i, overflow, cout, result, exp[i][W+1], exp[i][W], exp[i][W-1:0], gd);
      end
    end
  endtask

  task automatic test_ignore();
    logic [W-1:0] prev;
    logic         prevc, prevv;
    prev = result; prevc = cout; prevv = overflow;
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01; opcode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      total++;
      if (busy !== 1'b1 || result !== prev || cout !== prevc || overflow !== prevv) begin
        bad++;
        $display("FAIL ignore_hold_%0d busy=%b r=%h exp busy=1 r=%h", i, busy, result, prev);
      end
      if (i == 2) begin start = 1'b1; a = 8'h55; b = 8'h22; opcode = 1'b1; end
      if (i == 3) start = 1'b0;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || result !== 8'h02 || cout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL ignore_result done=%b r=%h c=%b v=%b exp done=1 r=02 c=0 v=0", done, result, cout, overflow);
    end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_queue busy=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [3] = '{8'h01, 8'h10, 8'hF0};
    logic [W-1:0] ys [3] = '{8'h02, 8'h01, 8'h20};
    logic         ops[3] = '{1'b0, 1'b1, 1'b0};
    logic [W+1:0] e;
    int last_done, guard;
    last_done = -1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; a = xs[k]; b = ys[k]; opcode = ops[k];
      @(negedge clk);
      if (k == 2) start = 1'b0;
      guard = 0;
      while (!done && guard < 40) begin guard++; @(negedge clk); end
      e = model(xs[k], ys[k], ops[k]);
      total++;
      if (!done || {overflow, cout, result} !== e) begin
        bad++;
        $display("FAIL b2b_result_%0d got v=%b c=%b r=%h exp v=%b c=%b r=%h", k,
                 overflow, cout, result, e[W+1], e[W], e[W-1:0]);
      end
      if (last_done >= 0) begin
        total++;
        if (cyc - last_done != W + 1) begin
          bad++;
          $display("FAIL b2b_spacing_%0d got=%0d exp=%0d", k, cyc - last_done, W + 1);
        end
      end
      last_done = cyc;
    end
    total++;
    if (result !== 8'h10 || cout !== 1'b1) begin
      bad++; $display("FAIL b2b_third r=%h c=%b exp r=10 c=1", result, cout);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_run();
    int seen;
    @(negedge clk);
    start = 1'b1; a = 8'h33; b = 8'h44; opcode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h00 || cout !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_clear busy=%b done=%b r=%h c=%b v=%b exp all 0", busy, done, result, cout, overflow);
    end
    seen = 0;
    repeat (W + 3) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL abort_no_done got=%0d active cycles exp=0", seen); end
    reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_start_idle busy=%b exp=0", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_start_stay busy=%b done=%b exp=0,0", busy, done); end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         sub;
    logic [W+1:0] e;
    int nb; logic gd;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); sub = 1'($urandom_range(0, 1));
      e = model(x, y, sub);
      run_op(x, y, sub, nb, gd);
      total++;
      if (!gd || nb != W || {overflow, cout, result} !== e) begin
        bad++;
        $display("FAIL rand_%0d a=%h b=%h op=%b got v=%b c=%b r=%h busy=%0d exp v=%b c=%b r=%h busy=%0d",
                 i, x, y, sub, overflow, cout, result, nb, e[W+1], e[W], e[W-1:0], W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_ignore();
    test_back_to_back();
    test_reset_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_adder_subtractor.md
Name: serial_adder_subtractor

Overview:
- Bit-serial two's-complement adder/subtractor. Processes one bit per clock, LSB first, with a single carry flip-flop.
- Operand and opcode semantics match the team's combinational full adder/subtractor: opcode 0 = add, opcode 1 = subtract. Subtraction inverts b and forces carry-in 1.
- Area-cheap alternative to the ripple datapath for control paths that tolerate WIDTH-cycle latency.
- Uses a start/busy/done handshake toward the issuing controller.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE state
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
opcode  input  1  0 = A+B, 1 = A-B; captured on accepted start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result, cout and overflow are valid from this cycle on
result  output  WIDTH  sum or difference (mod 2^WIDTH)
cout  output  1  carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset, checked at the clock edge with priority over everything:
  - state = IDLE
  - busy = 0, done = 0, result = 0, cout = 0, overflow = 0
  - internal shift registers, carry and bit counter cleared
- States:
  - IDLE: busy = 0, done = 0. On start = 1, go to RUN.
  - RUN: busy = 1, done = 0. Processes bit i at count i, for i = 0..WIDTH-1. After bit WIDTH-1, go to DONE.
  - DONE: busy = 0, done = 1 for exactly this one cycle. Next state is RUN if start = 1, else IDLE.
- Accepting start (in IDLE or DONE), at the edge where start is sampled:
  - latch a and b into shift registers and latch opcode
  - carry <= opcode
  - count <= 0
- Each RUN edge:
  - bi = b_sh[0] ^ op
  - s = a_sh[0] ^ bi ^ carry
  - carry <= (a_sh[0] & bi) | (bi & carry) | (a_sh[0] & carry)
  - a_sh and b_sh shift right by one
  - s shifts into the MSB of the internal sum register
  - count increments
- At the edge processing bit WIDTH-1, also:
  - record the carry into the MSB (the carry before the update)
  - load result with the completed sum register
  - cout <= new carry
  - overflow <= carry_in_msb ^ new carry
- Latency:
  - start sampled at edge E0; busy high from E0 until edge E_WIDTH
  - done high between E_WIDTH and E_WIDTH+1
  - total is WIDTH+1 cycles from start to the first cycle of the next operation
- Output holding: result, cout and overflow change only at completion. They hold their values through IDLE and through the following RUN, until the next completion or reset.
- Boundary cases:
  - start while busy (RUN): ignored, no queuing.
  - a, b or opcode changing during RUN: no effect.
  - start held high continuously: back-to-back operations, one every WIDTH+1 cycles. done pulses each time.
  - reset during RUN: the operation is aborted and outputs are cleared. No done pulse occurs.
  - reset and start in the same cycle: reset wins. start is not accepted.
  - Operand wrap-around: result is modulo 2^WIDTH. Overflow is flagged through cout and overflow, never saturated.

Test Plan:
1. WIDTH = 8, add 0x35 + 0x4A, start pulsed one cycle -> busy high for exactly 8 cycles, done pulse on the 9th cycle. result = 0x7F, cout = 0, overflow = 0.
2. Add 0xFF + 0x01 -> result = 0x00, cout = 1, overflow = 0. Add 0x7F + 0x01 -> result = 0x80, cout = 0, overflow = 1.
3. Subtract 0x05 - 0x07 -> result = 0xFE, cout = 0, overflow = 0. Subtract 0x80 - 0x01 -> result = 0x7F, cout = 1, overflow = 1. Subtract 0x10 - 0x10 -> result = 0x00, cout = 1.
4. Start 0x01 + 0x01; pulse start with different operands and change a/b on cycle 3 of RUN -> second start ignored; result = 0x02 at done; previous result held during RUN.
5. Start held high across three operations (0x01+0x02, 0x10-0x01, 0xF0+0x20) -> done pulses exactly 9 cycles apart. Results are 0x03, 0x0F, 0x10 (cout = 1 on the third).
6. Reset asserted on the 4th RUN cycle -> next cycle busy = 0, done = 0, result = 0, cout = 0, overflow = 0, no done pulse. Reset together with start -> stays IDLE.
